// File: rtl/uop_buf_port_arbiter.sv
// Shares the single-port loop-buffer BRAM between capture writes and replay reads,
// and sequences a full-buffer clear that fills every entry with NOP_WORD.
module uop_buf_port_arbiter #(
    parameter int                ADDR_W       = 6,
    parameter int                DATA_W       = 32,
    parameter int                STARVE_LIMIT = 4,
    parameter logic [DATA_W-1:0] NOP_WORD     = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              clr_busy,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [3:0]        LIMIT     = 4'(STARVE_LIMIT);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic [3:0]        starve_cnt, starve_nxt;
    logic              grant_rd, grant_wr;
    logic              busy_c, en_c, we_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] wdata_c;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        starve_nxt  = starve_cnt;
        grant_rd    = 1'b0;
        grant_wr    = 1'b0;
        busy_c      = 1'b0;
        en_c        = 1'b0;
        we_c        = 1'b0;
        addr_c      = '0;
        wdata_c     = '0;

        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end else begin
                    // Replay wins ties until capture has been denied LIMIT cycles in a row.
                    grant_rd = rd_valid && (!wr_valid || (starve_cnt < LIMIT));
                    grant_wr = wr_valid && !grant_rd;
                end

                if (grant_wr) begin
                    en_c    = 1'b1;
                    we_c    = 1'b1;
                    addr_c  = wr_addr;
                    wdata_c = wr_data;
                end else if (grant_rd) begin
                    en_c   = 1'b1;
                    addr_c = rd_addr;
                end

                if (!wr_valid || grant_wr)
                    starve_nxt = '0;
                else if (starve_cnt < LIMIT)
                    starve_nxt = starve_cnt + 4'd1;
            end

            CLEAR: begin
                busy_c  = 1'b1;
                en_c    = 1'b1;
                we_c    = 1'b1;
                addr_c  = clr_cnt;
                wdata_c = NOP_WORD;
                if (clr_cnt == LAST_ADDR) begin
                    state_nxt   = IDLE;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            clr_cnt       <= '0;
            starve_cnt    <= '0;
            rd_data_valid <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state         <= state_nxt;
            clr_cnt       <= clr_cnt_nxt;
            starve_cnt    <= starve_nxt;
            rd_data_valid <= grant_rd;
        end
    end

    // Combinational outputs are masked by reset so nothing leaks out while it is held.
    assign wr_ready  = reset & grant_wr;
    assign rd_ready  = reset & grant_rd;
    assign clr_busy  = reset & busy_c;
    assign mem_en    = reset & en_c;
    assign mem_we    = reset & we_c;
    assign mem_addr  = reset ? addr_c  : '0;
    assign mem_wdata = reset ? wdata_c : '0;
    assign rd_data   = rd_data_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_uop_buf_port_arbiter.sv
// Directed bench for uop_buf_port_arbiter with a behavioural single-port BRAM behind it.
module tb_uop_buf_port_arbiter;

    localparam int          ADDR_W = 6;
    localparam int          DATA_W = 32;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              reset;
    logic              clr_req;
    logic              clr_busy;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uop_buf_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4), .NOP_WORD(NOP)
    ) dut (
        .clk(clk), .reset(reset), .clr_req(clr_req), .clr_busy(clr_busy),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_data_valid(rd_data_valid), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Caller has just presented clr_req in IDLE; walks the 64 clear cycles and the first IDLE cycle.
    task automatic run_clear(input logic with_rd, input logic reclr);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            clr_req  = reclr && (i == 10);
            rd_valid = with_rd;
            #1;
            check("clr_busy",    clr_busy, 1);
            check("clr_mem_en",  mem_en, 1);
            check("clr_mem_we",  mem_we, 1);
            check("clr_addr",    mem_addr, i);
            check("clr_wdata",   mem_wdata, NOP);
            check("clr_wr_rdy",  wr_ready, 0);
            check("clr_rd_rdy",  rd_ready, 0);
            check("clr_rdv",     rd_data_valid, 0);
        end
        @(negedge clk);
        clr_req = 1'b0;
        #1;
        check("clr_done_busy", clr_busy, 0);
        check("clr_done_rdy",  rd_ready, with_rd);
        check("clr_done_en",   mem_en, with_rd);
    endtask

    initial begin
        logic [9:0] wr_pat;
        logic       prev_rd;

        // Reset with both valids high: every output must stay at 0.
        reset = 1'b0; clr_req = 1'b0;
        wr_valid = 1'b1; wr_addr = 6'd5; wr_data = 32'hDEAD;
        rd_valid = 1'b1; rd_addr = 6'd5;
        repeat (2) @(negedge clk);
        #1;
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_ready", rd_ready, 0);
        check("rst_mem_en",   mem_en, 0);
        check("rst_mem_we",   mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_wdata",    mem_wdata, 0);
        check("rst_busy",     clr_busy, 0);
        check("rst_rdv",      rd_data_valid, 0);

        // Lone write.
        @(negedge clk);
        reset = 1'b1; rd_valid = 1'b0;
        #1;
        check("t1_wr_ready", wr_ready, 1);
        check("t1_rd_ready", rd_ready, 0);
        check("t1_mem_en",   mem_en, 1);
        check("t1_mem_we",   mem_we, 1);
        check("t1_addr",     mem_addr, 5);
        check("t1_wdata",    mem_wdata, 32'hDEAD);

        // Lone read of the same entry.
        @(negedge clk);
        wr_valid = 1'b0; rd_valid = 1'b1;
        #1;
        check("t2_rd_ready", rd_ready, 1);
        check("t2_wr_ready", wr_ready, 0);
        check("t2_mem_we",   mem_we, 0);
        check("t2_addr",     mem_addr, 5);
        check("t2_rdv_early", rd_data_valid, 0);
        @(negedge clk);
        rd_valid = 1'b0;
        #1;
        check("t2_rdv",     rd_data_valid, 1);
        check("t2_rd_data", rd_data, 32'hDEAD);
        check("t2_idle_en", mem_en, 0);
        @(negedge clk);
        #1;
        check("t2_rdv_drop", rd_data_valid, 0);

        // Contention: four reads, one forced write, repeating.
        wr_pat  = 10'b10_0001_0000;
        prev_rd = 1'b0;
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 6'd7; wr_data = 32'hBEEF;
        rd_valid = 1'b1; rd_addr = 6'd5;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("t3_wr_ready", wr_ready, wr_pat[i]);
            check("t3_rd_ready", rd_ready, !wr_pat[i]);
            check("t3_addr",     mem_addr, wr_pat[i] ? 7 : 5);
            check("t3_rdv",      rd_data_valid, prev_rd);
            if (prev_rd) check("t3_rd_data", rd_data, 32'hDEAD);
            prev_rd = !wr_pat[i];
            @(negedge clk);
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
        check("t3_mem7", mem[7], 32'hBEEF);

        // Clear from a quiet IDLE.
        clr_req = 1'b1;
        #1;
        check("t4_req_busy", clr_busy, 0);
        check("t4_req_en",   mem_en, 0);
        run_clear(1'b0, 1'b0);
        check("t4_mem5",  mem[5], NOP);
        check("t4_mem7",  mem[7], NOP);
        check("t4_mem63", mem[63], NOP);

        // Read granted just before clr_req, read held pending, second clr_req mid-clear.
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 6'd3; wr_data = 32'hCAFE;
        #1;
        check("t5_wr_ready", wr_ready, 1);
        @(negedge clk);
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 6'd3;
        #1;
        check("t5_rd_ready", rd_ready, 1);
        @(negedge clk);
        clr_req = 1'b1;
        #1;
        check("t5_req_rd_rdy", rd_ready, 0);
        check("t5_req_wr_rdy", wr_ready, 0);
        check("t5_req_en",     mem_en, 0);
        check("t5_req_rdv",    rd_data_valid, 1);
        check("t5_req_data",   rd_data, 32'hCAFE);
        run_clear(1'b1, 1'b1);
        @(negedge clk);
        rd_valid = 1'b0;
        #1;
        check("t5_post_rdv",  rd_data_valid, 1);
        check("t5_post_data", rd_data, NOP);

        // Reset in the middle of a clear.
        @(negedge clk);
        clr_req = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            clr_req = 1'b0;
        end
        #1;
        check("t6_at20_addr", mem_addr, 20);
        wr_valid = 1'b1; rd_valid = 1'b1; reset = 1'b0;
        #1;
        check("t6_rst_busy",  clr_busy, 0);
        check("t6_rst_en",    mem_en, 0);
        check("t6_rst_we",    mem_we, 0);
        check("t6_rst_addr",  mem_addr, 0);
        check("t6_rst_wdata", mem_wdata, 0);
        check("t6_rst_wrdy",  wr_ready, 0);
        check("t6_rst_rrdy",  rd_ready, 0);
        check("t6_rst_rdv",   rd_data_valid, 0);
        check("t6_rst_data",  rd_data, 0);
        @(negedge clk);
        reset = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0;
        #1;
        check("t6_rel_busy", clr_busy, 0);
        check("t6_rel_rdv",  rd_data_valid, 0);
        check("t6_rel_en",   mem_en, 0);
        @(negedge clk);
        rd_valid = 1'b1; rd_addr = 6'd5;
        #1;
        check("t6_idle_rdy",  rd_ready, 1);
        check("t6_idle_busy", clr_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
